// File: rtl/sdram_ctrl_fsm_burst_pkg.sv
// Shared encodings for the burst-capable SDRAM controller main FSM:
// command-bus mux selects, FSM state type and a mux-restore helper.
package sdram_ctrl_fsm_burst_pkg;

  localparam logic [1:0] MUX_INIT = 2'd0;
  localparam logic [1:0] MUX_REF  = 2'd1;
  localparam logic [1:0] MUX_WR   = 2'd2;
  localparam logic [1:0] MUX_RD   = 2'd3;

  typedef enum logic [3:0] {
    INIT_START = 4'd0,
    INIT_WAIT  = 4'd1,
    IDLE       = 4'd2,
    REF_START  = 4'd3,
    REF_WAIT   = 4'd4,
    WR_START   = 4'd5,
    WR_WAIT    = 4'd6,
    WR_NEXT    = 4'd7,
    RD_START   = 4'd8,
    RD_WAIT    = 4'd9
  } state_e;

  // Bus owner to restore when a refresh hands control back to a state.
  function automatic logic [1:0] mux_for(state_e s);
    case (s)
      WR_START, WR_WAIT, WR_NEXT: return MUX_WR;
      RD_START, RD_WAIT:          return MUX_RD;
      default:                    return MUX_REF;
    endcase
  endfunction

endpackage

// File: rtl/sdram_ctrl_fsm_burst_ref_debt.sv
// Saturating refresh-debt counter: rt_flag ticks add debt, completed
// refreshes pay it back; a tick at the ceiling sets a sticky overflow.
module sdram_ref_debt #(
  parameter int unsigned REF_DEBT_MAX = 4
) (
  input  logic clk,
  input  logic soft_rst,
  input  logic enable,
  input  logic rt_flag,
  input  logic ref_done,
  output logic debt_nz,
  output logic debt_full,
  output logic ref_overflow
);

  localparam int unsigned DEBT_W = $clog2(REF_DEBT_MAX + 1);
  localparam logic [DEBT_W-1:0] DEBT_CEIL = DEBT_W'(REF_DEBT_MAX);

  logic [DEBT_W-1:0] debt_q;
  logic [DEBT_W-1:0] debt_d;
  logic              ovf_d;

  always_comb begin
    debt_d = debt_q;
    ovf_d  = ref_overflow;
    if (enable) begin
      if (rt_flag && !ref_done) begin
        if (debt_q == DEBT_CEIL) ovf_d = 1'b1;
        else                     debt_d = debt_q + DEBT_W'(1);
      end else if (ref_done && !rt_flag && (debt_q != '0)) begin
        debt_d = debt_q - DEBT_W'(1);
      end
    end
  end

  // Flags are registered from the next count so they line up with debt_q.
  always_ff @(posedge clk or posedge soft_rst) begin
    if (soft_rst) begin
      debt_q       <= '0;
      debt_nz      <= 1'b0;
      debt_full    <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      debt_q       <= debt_d;
      debt_nz      <= (debt_d != '0);
      debt_full    <= (debt_d == DEBT_CEIL);
      ref_overflow <= ovf_d;
    end
  end

endmodule

// File: rtl/sdram_ctrl_fsm_burst.sv
// SDRAM controller main FSM with Avalon bursts (one engine command per beat,
// column auto-increment) and refresh postponement up to a debt ceiling.
module sdram_ctrl_fsm_burst
  import sdram_ctrl_fsm_burst_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ROW_W        = 13,
  parameter int unsigned COL_W        = 10,
  parameter int unsigned BA_W         = 2,
  parameter int unsigned BURST_W      = 4,
  parameter int unsigned REF_DEBT_MAX = 4,
  localparam int unsigned ADDR_W      = BA_W + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              soft_rst,
  input  logic [ADDR_W-1:0] local_addr,
  input  logic              local_write,
  input  logic              local_read,
  input  logic [BURST_W-1:0] local_burstcount,
  input  logic [DATA_W-1:0] local_wdata,
  output logic              local_ready,
  output logic [DATA_W-1:0] local_rdata,
  output logic              local_rddatavalid,
  output logic              init_en,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  input  logic              init_done,
  input  logic              ref_done,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              rt_en,
  input  logic              rt_flag,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [BA_W-1:0]   ba,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [1:0]        smux,
  output logic              ref_overflow
);

  state_e               state_q, state_d;
  state_e               resume_q, resume_d;
  logic [BURST_W-1:0]   beats_q, beats_d;

  logic                 local_ready_d, rddatavalid_d;
  logic                 init_en_d, ref_en_d, wr_en_d, rd_en_d, rt_en_d;
  logic [DATA_W-1:0]    rdata_d, wdata_d;
  logic [ROW_W-1:0]     row_d;
  logic [COL_W-1:0]     col_d;
  logic [BA_W-1:0]      ba_d;
  logic [1:0]           smux_d;

  logic                 debt_nz, debt_full, ref_done_acc;

  // Only a refresh the FSM is actually waiting on pays back debt.
  assign ref_done_acc = ref_done && (state_q == REF_WAIT);

  sdram_ref_debt #(
    .REF_DEBT_MAX (REF_DEBT_MAX)
  ) u_ref_debt (
    .clk          (clk),
    .soft_rst     (soft_rst),
    .enable       (rt_en),
    .rt_flag      (rt_flag),
    .ref_done     (ref_done_acc),
    .debt_nz      (debt_nz),
    .debt_full    (debt_full),
    .ref_overflow (ref_overflow)
  );

  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    beats_d       = beats_q;
    local_ready_d = 1'b0;
    rddatavalid_d = 1'b0;
    init_en_d     = 1'b0;
    ref_en_d      = 1'b0;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    rt_en_d       = rt_en;
    rdata_d       = local_rdata;
    wdata_d       = wdata;
    row_d         = row;
    col_d         = col;
    ba_d          = ba;
    smux_d        = smux;

    case (state_q)
      INIT_START: begin
        init_en_d = 1'b1;
        state_d   = INIT_WAIT;
      end
      INIT_WAIT: if (init_done) begin
        rt_en_d  = 1'b1;
        smux_d   = MUX_REF;
        resume_d = IDLE;
        state_d  = REF_START;
      end
      IDLE: begin
        if (debt_nz) begin
          resume_d = IDLE;
          state_d  = REF_START;
        end else if (local_write || local_read) begin
          {ba_d, row_d, col_d} = local_addr;
          beats_d       = (local_burstcount == '0) ? BURST_W'(1) : local_burstcount;
          local_ready_d = 1'b1;
          if (local_write) begin
            wdata_d = local_wdata;
            smux_d  = MUX_WR;
            state_d = WR_START;
          end else begin
            smux_d  = MUX_RD;
            state_d = RD_START;
          end
        end
      end
      REF_START: begin
        ref_en_d = 1'b1;
        smux_d   = MUX_REF;
        state_d  = REF_WAIT;
      end
      REF_WAIT: if (ref_done) begin
        smux_d  = mux_for(resume_q);
        state_d = resume_q;
      end
      WR_START: begin
        wr_en_d = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: if (wr_done) begin
        beats_d = beats_q - BURST_W'(1);
        if (beats_q == BURST_W'(1)) begin
          smux_d  = MUX_REF;
          state_d = IDLE;
        end else begin
          col_d   = col + COL_W'(1);
          state_d = WR_NEXT;
        end
      end
      WR_NEXT: begin
        if (debt_full) begin
          resume_d = WR_NEXT;
          state_d  = REF_START;
        end else if (local_write) begin
          local_ready_d = 1'b1;
          wdata_d       = local_wdata;
          state_d       = WR_START;
        end
      end
      RD_START: begin
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (rd_done) begin
        rdata_d       = rdata;
        rddatavalid_d = 1'b1;
        beats_d       = beats_q - BURST_W'(1);
        col_d         = col + COL_W'(1);
        if (beats_q == BURST_W'(1)) begin
          smux_d  = MUX_REF;
          state_d = IDLE;
        end else if (debt_full) begin
          resume_d = RD_START;
          state_d  = REF_START;
        end else begin
          state_d = RD_START;
        end
      end
      default: state_d = INIT_START;
    endcase
  end

  always_ff @(posedge clk or posedge soft_rst) begin
    if (soft_rst) begin
      state_q           <= INIT_START;
      resume_q          <= IDLE;
      beats_q           <= '0;
      local_ready       <= 1'b0;
      local_rdata       <= '0;
      local_rddatavalid <= 1'b0;
      init_en           <= 1'b0;
      ref_en            <= 1'b0;
      wr_en             <= 1'b0;
      rd_en             <= 1'b0;
      rt_en             <= 1'b0;
      row               <= '0;
      col               <= '0;
      ba                <= '0;
      wdata             <= '0;
      smux              <= MUX_INIT;
    end else begin
      state_q           <= state_d;
      resume_q          <= resume_d;
      beats_q           <= beats_d;
      local_ready       <= local_ready_d;
      local_rdata       <= rdata_d;
      local_rddatavalid <= rddatavalid_d;
      init_en           <= init_en_d;
      ref_en            <= ref_en_d;
      wr_en             <= wr_en_d;
      rd_en             <= rd_en_d;
      rt_en             <= rt_en_d;
      row               <= row_d;
      col               <= col_d;
      ba                <= ba_d;
      wdata             <= wdata_d;
      smux              <= smux_d;
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_fsm_burst.sv
// Directed bench for sdram_ctrl_fsm_burst: table of burst transactions plus
// hand sequences for init, refresh postponement, overflow and mid-burst reset.
module tb_sdram_ctrl_fsm_burst;

  localparam int unsigned DATA_W = 32, ROW_W = 13, COL_W = 10, BA_W = 2;
  localparam int unsigned BURST_W = 4, REF_DEBT_MAX = 2;
  localparam int unsigned ADDR_W = BA_W + ROW_W + COL_W;

  logic              clk, soft_rst;
  logic [ADDR_W-1:0] local_addr;
  logic              local_write, local_read;
  logic [BURST_W-1:0] local_burstcount;
  logic [DATA_W-1:0] local_wdata, local_rdata, wdata, rdata;
  logic              local_ready, local_rddatavalid;
  logic              init_en, ref_en, wr_en, rd_en, rt_en;
  logic              init_done, ref_done, wr_done, rd_done, rt_flag;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [BA_W-1:0]   ba;
  logic [1:0]        smux;
  logic              ref_overflow;

  sdram_ctrl_fsm_burst #(
    .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W),
    .BURST_W(BURST_W), .REF_DEBT_MAX(REF_DEBT_MAX)
  ) dut (
    .clk(clk), .soft_rst(soft_rst), .local_addr(local_addr),
    .local_write(local_write), .local_read(local_read),
    .local_burstcount(local_burstcount), .local_wdata(local_wdata),
    .local_ready(local_ready), .local_rdata(local_rdata),
    .local_rddatavalid(local_rddatavalid), .init_en(init_en), .ref_en(ref_en),
    .wr_en(wr_en), .rd_en(rd_en), .init_done(init_done), .ref_done(ref_done),
    .wr_done(wr_done), .rd_done(rd_done), .rt_en(rt_en), .rt_flag(rt_flag),
    .row(row), .col(col), .ba(ba), .wdata(wdata), .rdata(rdata), .smux(smux),
    .ref_overflow(ref_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [9:0]  col;
    logic [3:0]  bc;
    int          exp_beats;
    logic [9:0]  exp_last_col;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [9:0]  col;
    logic [31:0] wd;
    logic [1:0]  mux;
  } beat_t;

  int    checks = 0, failures = 0;
  int    cyc = 0, init_cnt = 0, init_cyc = 0, ref_cnt = 0, rv_cnt = 0;
  beat_t beat_q[$];
  int    ref_at_q[$];
  logic  ref_stall = 1'b0;
  int    e_init = 0, e_ref = 0, e_wr = 0, e_rd = 0;
  logic  rd_done_q = 1'b0;
  logic [31:0] rdata_q = '0;
  logic [9:0]  rd_col = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Observe DUT outputs first, then advance the engine models.
  initial begin
    init_done = 0; ref_done = 0; wr_done = 0; rd_done = 0; rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_done_q) begin
        chk("rddatavalid_latency", local_rddatavalid, 1'b1);
        chk("local_rdata", local_rdata, rdata_q);
      end else if (local_rddatavalid) begin
        chk("spurious_rddatavalid", local_rddatavalid, 1'b0);
      end
      if (local_rddatavalid) rv_cnt++;
      if (init_en) begin init_cnt++; init_cyc = cyc; end
      if (ref_en) begin ref_cnt++; ref_at_q.push_back(beat_q.size()); end
      if (wr_en || rd_en) beat_q.push_back('{wr_en, ba, row, col, wdata, smux});
      init_done = 0; ref_done = 0; wr_done = 0; rd_done = 0;
      if (soft_rst) begin
        e_init = 0; e_ref = 0; e_wr = 0; e_rd = 0;
      end else begin
        if (e_init > 0) begin e_init--; if (e_init == 0) init_done = 1; end
        if (e_ref > 0 && !ref_stall) begin e_ref--; if (e_ref == 0) ref_done = 1; end
        if (e_wr > 0) begin e_wr--; if (e_wr == 0) wr_done = 1; end
        if (e_rd > 0) begin
          e_rd--;
          if (e_rd == 0) begin rd_done = 1; rdata = 32'hC0DE_0000 | 32'(rd_col); end
        end
        if (init_en) e_init = 20;
        if (ref_en)  e_ref  = 3;
        if (wr_en)   e_wr   = 3;
        if (rd_en) begin e_rd = 3; rd_col = col; end
      end
      rd_done_q = rd_done;
      rdata_q   = rdata;
    end
  end

  task automatic wait_ready();
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk); #1;
      got = local_ready;
    end
    chk("local_ready_wait", got, 1'b1);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 600 && beat_q.size() < n; k++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic pulse_rt();
    @(negedge clk); #1;
    rt_flag = 1'b1;
    @(negedge clk); #1;
    rt_flag = 1'b0;
  endtask

  task automatic tick_at(input int n);
    wait_beats(n);
    rt_flag = 1'b1;
    @(negedge clk); #1;
    rt_flag = 1'b0;
  endtask

  task automatic do_xfer(input vec_t v, input logic [31:0] base);
    int nb;
    nb = (v.bc == 0) ? 1 : int'(v.bc);
    local_addr       = {v.ba, v.row, v.col};
    local_burstcount = v.bc;
    if (v.wr) begin
      for (int j = 0; j < nb; j++) begin
        local_write = 1'b1;
        local_wdata = base + 32'(j);
        wait_ready();
      end
      local_write = 1'b0;
    end else begin
      local_read = 1'b1;
      wait_ready();
      local_read = 1'b0;
    end
  endtask

  task automatic check_beats(input string tag, input vec_t v, input logic [31:0] base);
    chk({tag, "_beat_count"}, beat_q.size(), v.exp_beats);
    foreach (beat_q[j]) begin
      chk({tag, "_is_wr"}, beat_q[j].wr, v.wr);
      chk({tag, "_ba"}, beat_q[j].ba, v.ba);
      chk({tag, "_row"}, beat_q[j].row, v.row);
      chk({tag, "_col"}, beat_q[j].col, 10'(v.col + 10'(j)));
      chk({tag, "_smux_beat"}, beat_q[j].mux, v.wr ? 2'd2 : 2'd3);
      if (v.wr) chk({tag, "_wdata"}, beat_q[j].wd, base + 32'(j));
    end
    if (beat_q.size() > 0) chk({tag, "_last_col"}, beat_q[$].col, v.exp_last_col);
  endtask

  vec_t vecs[6];
  vec_t v8;
  int   r0, rv0, ic0, rt_cyc;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 2'd1, 13'h0005, 10'h3FE, 4'd0,  1,  10'h3FE};
    vecs[1] = '{1'b0, 2'd1, 13'h0005, 10'h3FE, 4'd4,  4,  10'h001};
    vecs[2] = '{1'b1, 2'd2, 13'h1ABC, 10'h010, 4'd3,  3,  10'h012};
    vecs[3] = '{1'b0, 2'd3, 13'h1FFF, 10'h3FF, 4'd1,  1,  10'h3FF};
    vecs[4] = '{1'b0, 2'd0, 13'h0000, 10'h3F8, 4'd15, 15, 10'h006};
    vecs[5] = '{1'b1, 2'd3, 13'h00AA, 10'h3FF, 4'd2,  2,  10'h000};
    v8      = '{1'b1, 2'd0, 13'h0123, 10'h100, 4'd8,  8,  10'h107};

    soft_rst = 1'b1; rt_flag = 1'b0;
    local_addr = '0; local_write = 0; local_read = 0; local_burstcount = '0; local_wdata = '0;

    // Reset state and init handshake.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_init_en", init_en, 1'b0);
    chk("rst_rt_en", rt_en, 1'b0);
    chk("rst_smux", smux, 2'd0);
    chk("rst_local_ready", local_ready, 1'b0);
    chk("rst_overflow", ref_overflow, 1'b0);
    soft_rst = 1'b0;
    rt_cyc = 0;
    for (int k = 0; k < 200 && !rt_en; k++) begin @(negedge clk); #1; rt_cyc = cyc; end
    chk("rt_en_after_init", rt_en, 1'b1);
    chk("init_done_to_rt_en", rt_cyc - init_cyc, 21);
    chk("init_en_pulses", init_cnt, 1);
    repeat (15) @(negedge clk);
    #1;
    chk("init_refresh_count", ref_cnt, 1);
    chk("idle_smux_ref", smux, 2'd1);

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) begin
      beat_q.delete();
      rv0 = rv_cnt;
      do_xfer(vecs[i], 32'hD000_0000 + 32'(i * 16));
      wait_beats(vecs[i].exp_beats);
      repeat (8) @(negedge clk);
      #1;
      check_beats($sformatf("vec%0d", i), vecs[i], 32'hD000_0000 + 32'(i * 16));
      if (vecs[i].wr) chk($sformatf("vec%0d_smux_end", i), smux, 2'd1);
      else            chk($sformatf("vec%0d_rdvalid_count", i), rv_cnt - rv0, vecs[i].exp_beats);
      chk($sformatf("vec%0d_ready_idle", i), local_ready, 1'b0);
    end

    // Write burst of 8 with two refresh ticks: yields once the debt hits the ceiling.
    beat_q.delete(); ref_at_q.delete();
    r0 = ref_cnt;
    fork
      do_xfer(v8, 32'hE000_0000);
      begin tick_at(2); tick_at(4); end
    join
    wait_beats(8);
    repeat (20) @(negedge clk);
    #1;
    check_beats("burst8", v8, 32'hE000_0000);
    chk("burst8_refreshes", ref_cnt - r0, 2);
    chk("burst8_ref_count_seen", ref_at_q.size(), 2);
    chk("burst8_ref_after_beat", ref_at_q[0], 4);
    chk("burst8_ref_after_burst", ref_at_q[1], 8);
    chk("burst8_smux_end", smux, 2'd1);

    // Overflow: refresh engine stalled while ticks pile up.
    ref_stall = 1'b1;
    r0 = ref_cnt;
    pulse_rt();
    repeat (5) @(negedge clk);
    #1;
    chk("ovf_refresh_started", ref_cnt - r0, 1);
    pulse_rt();
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_not_yet", ref_overflow, 1'b0);
    pulse_rt();
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_set", ref_overflow, 1'b1);
    ref_stall = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("ovf_sticky", ref_overflow, 1'b1);
    chk("ovf_drain_refreshes", ref_cnt - r0, 2);

    // Reset while a read burst waits on the read engine.
    beat_q.delete();
    rv0 = rv_cnt; ic0 = init_cnt;
    local_addr = {2'd2, 13'h0042, 10'h020};
    local_burstcount = 4'd4;
    local_read = 1'b1;
    wait_ready();
    local_read = 1'b0;
    wait_beats(1);
    #1 soft_rst = 1'b1;
    #1;
    chk("mrst_rd_en", rd_en, 1'b0);
    chk("mrst_rt_en", rt_en, 1'b0);
    chk("mrst_smux", smux, 2'd0);
    chk("mrst_overflow", ref_overflow, 1'b0);
    chk("mrst_col", col, 10'h000);
    chk("mrst_rddatavalid", local_rddatavalid, 1'b0);
    repeat (3) @(negedge clk);
    #1 soft_rst = 1'b0;
    for (int k = 0; k < 200 && !rt_en; k++) begin @(negedge clk); #1; end
    repeat (15) @(negedge clk);
    #1;
    chk("mrst_reinit", init_cnt - ic0, 1);
    chk("mrst_rt_en_again", rt_en, 1'b1);
    chk("mrst_no_rdvalid", rv_cnt - rv0, 0);
    chk("mrst_overflow_cleared", ref_overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
